// File: rtl/avalon_sdr_burst.sv
// avalon_sdr_burst: burst-mode Avalon-MM master that moves a flat vector of
// 32-bit elements between SDRAM and a register-file style port. Writes stream
// back-to-back bursts; reads are pipelined under an outstanding-word limit.
module avalon_sdr_burst #(
   parameter int  DATA_W      = 16,
   parameter int  MAX_NREAD   = 64,
   parameter int  MAX_NWRITE  = 64,
   parameter int  BURST_MAX   = 8,
   parameter int  MAX_PENDING = 16,
   localparam int BC_W        = $clog2(BURST_MAX) + 1
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     avm_m0_read,
   output logic                     avm_m0_write,
   output logic [31:0]              avm_m0_address,
   output logic [BC_W-1:0]          avm_m0_burstcount,
   output logic [DATA_W-1:0]        avm_m0_writedata,
   output logic [DATA_W/8-1:0]      avm_m0_byteenable,
   input  logic [DATA_W-1:0]        avm_m0_readdata,
   input  logic                     avm_m0_readdatavalid,
   input  logic                     avm_m0_waitrequest,
   input  logic [31:0]              sdr_baseaddr,
   input  logic [29:0]              sdr_nelems,
   output logic [32*MAX_NREAD-1:0]  sdr_readdata,
   input  logic [32*MAX_NWRITE-1:0] sdr_writedata,
   input  logic                     sdr_readstart,
   input  logic                     sdr_writestart,
   output logic                     sdr_readend,
   output logic                     sdr_writeend,
   output logic                     sdr_busy,
   output logic                     sdr_error,
   output logic                     irq,
   input  logic                     irq_clear
);

   localparam int W        = DATA_W / 8;
   localparam int W_LOG    = $clog2(W);
   localparam int WPE      = 32 / DATA_W;
   localparam int WPE_LOG  = $clog2(WPE);
   localparam int NMAX     = (MAX_NREAD > MAX_NWRITE) ? MAX_NREAD : MAX_NWRITE;
   localparam int CW       = $clog2(2 * NMAX + 1) + 1;
   localparam int PW       = $clog2(MAX_PENDING + BURST_MAX + 1) + 1;
   localparam int RD_WORDS = MAX_NREAD * WPE;

   localparam logic [CW-1:0] C_ONE  = CW'(1);
   localparam logic [CW-1:0] C_BMAX = CW'(BURST_MAX);
   localparam logic [CW-1:0] C_RDW  = CW'(RD_WORDS);
   localparam logic [PW-1:0] P_ONE  = PW'(1);
   localparam logic [PW-1:0] P_MAX  = PW'(MAX_PENDING);
   localparam logic [29:0]   NR_MAX = 30'(MAX_NREAD);
   localparam logic [29:0]   NW_MAX = 30'(MAX_NWRITE);

   typedef enum logic [2:0] {S_IDLE, S_WR_BURST, S_RD_CMD, S_RD_WAIT, S_DONE} state_t;

   state_t                  r_state, w_state_nxt;
   logic [31:0]             r_addr;
   logic [CW-1:0]           r_nwords;   // total words N of the transfer
   logic [CW-1:0]           r_req;      // write: first word of current burst; read: words requested
   logic [CW-1:0]           r_k;        // next write word index
   logic [CW-1:0]           r_rdidx;    // next read word slot
   logic [PW-1:0]           r_pending;  // read words requested but not yet returned
   logic                    r_dir_wr;
   logic                    r_error;
   logic                    r_irq;
   logic                    r_readend;
   logic                    r_writeend;
   logic [32*MAX_NREAD-1:0] r_readdata;

   logic                    w_read, w_write;
   logic                    w_take_wr, w_take_rd;
   logic                    w_bad_wr, w_bad_rd, w_misalign;
   logic                    w_wr_acc, w_rd_acc, w_beat, w_issue;
   logic [CW-1:0]           w_nwords, w_len, w_k_nxt;
   logic [PW-1:0]           w_len_p;
   logic [31:0]             w_inc;

   // Burst length saturates at BURST_MAX; the tail burst carries what is left.
   function automatic logic [CW-1:0] burst_len(input logic [CW-1:0] remain);
      if (remain >= C_BMAX) return C_BMAX;
      return remain;
   endfunction

   assign w_misalign = |sdr_baseaddr[W_LOG-1:0];
   assign w_bad_rd   = (sdr_nelems == 30'd0) | (sdr_nelems > NR_MAX) | w_misalign;
   assign w_bad_wr   = (sdr_nelems == 30'd0) | (sdr_nelems > NW_MAX) | w_misalign;
   assign w_nwords   = CW'(sdr_nelems) << WPE_LOG;
   // r_req only moves at burst boundaries, so len stays fixed across a burst
   assign w_len      = burst_len(r_nwords - r_req);
   assign w_len_p    = PW'(w_len);
   assign w_inc      = 32'(w_len) << W_LOG;
   assign w_k_nxt    = r_k + C_ONE;
   assign w_issue    = (r_pending + w_len_p) <= P_MAX;
   assign w_wr_acc   = w_write & ~avm_m0_waitrequest;
   assign w_rd_acc   = w_read & ~avm_m0_waitrequest;
   assign w_beat     = avm_m0_readdatavalid & (r_state != S_IDLE) & (r_state != S_DONE);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state and bus command decode.
   always_comb begin
      w_state_nxt = r_state;
      w_read      = 1'b0;
      w_write     = 1'b0;
      w_take_wr   = 1'b0;
      w_take_rd   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (sdr_writestart) begin
               w_take_wr   = 1'b1;
               w_state_nxt = w_bad_wr ? S_DONE : S_WR_BURST;
            end else if (sdr_readstart) begin
               w_take_rd   = 1'b1;
               w_state_nxt = w_bad_rd ? S_DONE : S_RD_CMD;
            end
         end
         S_WR_BURST: begin
            w_write = 1'b1;
            if (!avm_m0_waitrequest && (w_k_nxt == r_nwords)) w_state_nxt = S_DONE;
         end
         S_RD_CMD: begin
            w_read = w_issue;
            if (w_issue && !avm_m0_waitrequest && ((r_req + w_len) == r_nwords))
               w_state_nxt = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (r_rdidx == r_nwords) w_state_nxt = S_DONE;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Transfer bookkeeping, read capture, completion flags and irq.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr     <= '0;
         r_nwords   <= '0;
         r_req      <= '0;
         r_k        <= '0;
         r_rdidx    <= '0;
         r_pending  <= '0;
         r_dir_wr   <= 1'b0;
         r_error    <= 1'b0;
         r_irq      <= 1'b0;
         r_readend  <= 1'b0;
         r_writeend <= 1'b0;
         r_readdata <= '0;
      end else begin
         r_readend  <= 1'b0;
         r_writeend <= 1'b0;
         if (r_state == S_DONE) begin
            r_readend  <= ~r_dir_wr;
            r_writeend <= r_dir_wr;
            r_irq      <= 1'b1;
         end else if (irq_clear) begin
            r_irq <= 1'b0;
         end

         if (w_take_wr | w_take_rd) begin
            r_addr   <= sdr_baseaddr;
            r_nwords <= w_nwords;
            r_req    <= '0;
            r_k      <= '0;
            r_rdidx  <= '0;
            r_dir_wr <= w_take_wr;
            r_error  <= w_take_wr ? w_bad_wr : w_bad_rd;
            if (w_take_rd) r_readdata <= '0;
         end

         if (w_wr_acc) begin
            r_k <= w_k_nxt;
            if (w_k_nxt == (r_req + w_len)) begin
               r_req  <= w_k_nxt;
               r_addr <= r_addr + w_inc;
            end
         end

         if (w_rd_acc) begin
            r_req  <= r_req + w_len;
            r_addr <= r_addr + w_inc;
         end

         if (w_beat) begin
            if (r_rdidx < C_RDW) r_readdata[DATA_W*r_rdidx +: DATA_W] <= avm_m0_readdata;
            r_rdidx <= r_rdidx + C_ONE;
         end

         if (w_take_wr | w_take_rd)
            r_pending <= '0;
         else
            r_pending <= r_pending + (w_rd_acc ? w_len_p : '0)
                         - ((w_beat && (r_pending != '0)) ? P_ONE : '0);
      end
   end

   assign avm_m0_read       = w_read;
   assign avm_m0_write      = w_write;
   assign avm_m0_address    = r_addr;
   assign avm_m0_burstcount = (w_read | w_write) ? BC_W'(w_len) : '0;
   assign avm_m0_writedata  = w_write ? sdr_writedata[DATA_W*r_k +: DATA_W] : '0;
   assign avm_m0_byteenable = {W{w_read | w_write}};
   assign sdr_readdata      = r_readdata;
   assign sdr_readend       = r_readend;
   assign sdr_writeend      = r_writeend;
   assign sdr_busy          = (r_state != S_IDLE);
   assign sdr_error         = r_error;
   assign irq               = r_irq;

endmodule

// File: tb/tb_avalon_sdr_burst.sv
// Bench for avalon_sdr_burst: two instances (default geometry and a small
// BURST_MAX=4 / MAX_PENDING=8 one) share an Avalon slave model that checks
// commands and write beats against queued expectations and returns read data.
`timescale 1ns/1ps
module tb_avalon_sdr_burst;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1;
   logic        waitreq = 1'b0;
   logic        rdv = 1'b0;
   logic [15:0] rdata = 16'h0;
   logic [31:0] base = 32'h0;
   logic [29:0] nelems = 30'h0;
   logic        irq_clear = 1'b0;
   logic        a_rs = 1'b0, a_ws = 1'b0, b_rs = 1'b0, b_ws = 1'b0;

   logic          a_read, a_write, a_rend, a_wend, a_busy, a_err, a_irq;
   logic [31:0]   a_addr;
   logic [3:0]    a_bc;
   logic [15:0]   a_wd;
   logic [1:0]    a_be;
   logic [2047:0] a_rvec;
   logic [2047:0] a_wvec = '0;

   logic          b_read, b_write, b_rend, b_wend, b_busy, b_err, b_irq;
   logic [31:0]   b_addr;
   logic [2:0]    b_bc;
   logic [15:0]   b_wd;
   logic [1:0]    b_be;
   logic [511:0]  b_rvec;
   logic [511:0]  b_wvec = '0;

   avalon_sdr_burst #(.DATA_W(16)) u_a (
      .clk(clk), .reset(reset),
      .avm_m0_read(a_read), .avm_m0_write(a_write), .avm_m0_address(a_addr),
      .avm_m0_burstcount(a_bc), .avm_m0_writedata(a_wd), .avm_m0_byteenable(a_be),
      .avm_m0_readdata(rdata), .avm_m0_readdatavalid(rdv), .avm_m0_waitrequest(waitreq),
      .sdr_baseaddr(base), .sdr_nelems(nelems), .sdr_readdata(a_rvec), .sdr_writedata(a_wvec),
      .sdr_readstart(a_rs), .sdr_writestart(a_ws), .sdr_readend(a_rend), .sdr_writeend(a_wend),
      .sdr_busy(a_busy), .sdr_error(a_err), .irq(a_irq), .irq_clear(irq_clear));

   avalon_sdr_burst #(.DATA_W(16), .MAX_NREAD(16), .MAX_NWRITE(16), .BURST_MAX(4), .MAX_PENDING(8)) u_b (
      .clk(clk), .reset(reset),
      .avm_m0_read(b_read), .avm_m0_write(b_write), .avm_m0_address(b_addr),
      .avm_m0_burstcount(b_bc), .avm_m0_writedata(b_wd), .avm_m0_byteenable(b_be),
      .avm_m0_readdata(rdata), .avm_m0_readdatavalid(rdv), .avm_m0_waitrequest(waitreq),
      .sdr_baseaddr(base), .sdr_nelems(nelems), .sdr_readdata(b_rvec), .sdr_writedata(b_wvec),
      .sdr_readstart(b_rs), .sdr_writestart(b_ws), .sdr_readend(b_rend), .sdr_writeend(b_wend),
      .sdr_busy(b_busy), .sdr_error(b_err), .irq(b_irq), .irq_clear(irq_clear));

   // slave model serves instance selected by sel
   logic        sel = 1'b0;
   logic        s_read, s_write;
   logic [31:0] s_addr;
   logic [3:0]  s_bc;
   logic [15:0] s_wd;
   logic [1:0]  s_be;
   assign s_read  = sel ? b_read  : a_read;
   assign s_write = sel ? b_write : a_write;
   assign s_addr  = sel ? b_addr  : a_addr;
   assign s_bc    = sel ? {1'b0, b_bc} : a_bc;
   assign s_wd    = sel ? b_wd    : a_wd;
   assign s_be    = sel ? b_be    : a_be;

   typedef struct { logic [31:0] addr; int bc; logic [15:0] data; } wexp_t;
   typedef struct { logic [31:0] addr; int bc; } rexp_t;
   wexp_t       wr_q[$];
   rexp_t       rc_q[$];
   logic [15:0] rd_exp[$];
   int          rq_due[$];

   int total = 0, bad = 0;
   int cyc = 0, last_due = 0, beat_n = 0, cmd_cnt = 0, bus_act = 0;
   bit wait_mode = 1'b0, hold = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Avalon slave: drive waitrequest/return beats, then check the command in flight.
   always @(negedge clk) begin
      int    due, tmp;
      wexp_t we;
      rexp_t re;
      waitreq = wait_mode ? ~waitreq : 1'b0;
      rdv = 1'b0;
      if (!hold && rq_due.size() > 0 && rq_due[0] <= cyc) begin
         tmp   = rq_due.pop_front();
         rdv   = 1'b1;
         rdata = 16'hA000 + 16'(beat_n);
         beat_n++;
         rd_exp.push_back(rdata);
      end
      #1;
      if (s_read | s_write) begin
         bus_act++;
         total++;
         if (s_be !== 2'b11) begin bad++; $display("FAIL byteenable got=%b want=11", s_be); end
      end
      if (s_read && !waitreq) begin
         cmd_cnt++;
         total++;
         if (rc_q.size() == 0) begin
            bad++; $display("FAIL rd_cmd_extra got addr=%h bc=%0d want none", s_addr, s_bc);
         end else begin
            re = rc_q.pop_front();
            if (s_addr !== re.addr || s_bc !== 4'(re.bc)) begin
               bad++; $display("FAIL rd_cmd got addr=%h bc=%0d want addr=%h bc=%0d", s_addr, s_bc, re.addr, re.bc);
            end
         end
         for (int i = 0; i < int'(s_bc); i++) begin
            due = (cyc + 2 > last_due + 1) ? cyc + 2 : last_due + 1;
            rq_due.push_back(due);
            last_due = due;
         end
      end
      if (s_write && !waitreq) begin
         total++;
         if (wr_q.size() == 0) begin
            bad++; $display("FAIL wr_beat_extra got addr=%h data=%h want none", s_addr, s_wd);
         end else begin
            we = wr_q.pop_front();
            if (s_addr !== we.addr || s_bc !== 4'(we.bc) || s_wd !== we.data) begin
               bad++; $display("FAIL wr_beat got addr=%h bc=%0d data=%h want addr=%h bc=%0d data=%h",
                               s_addr, s_bc, s_wd, we.addr, we.bc, we.data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #3;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      total++;
      if ({a_read, a_write, a_addr, a_bc, a_wd, a_be, a_rend, a_wend, a_busy, a_err, a_irq} !== '0 || a_rvec !== '0) begin
         bad++; $display("FAIL reset_a got busy=%b read=%b write=%b addr=%h irq=%b want all 0", a_busy, a_read, a_write, a_addr, a_irq);
      end
      total++;
      if ({b_read, b_write, b_addr, b_bc, b_wd, b_be, b_rend, b_wend, b_busy, b_err, b_irq} !== '0 || b_rvec !== '0) begin
         bad++; $display("FAIL reset_b got busy=%b read=%b write=%b addr=%h irq=%b want all 0", b_busy, b_read, b_write, b_addr, b_irq);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_read_burst();
      bit ok = 1'b0;
      sel = 1'b0; rd_exp.delete(); cmd_cnt = 0;
      base = 32'h100; nelems = 30'd3;
      rc_q.push_back('{addr: 32'h100, bc: 6});
      a_rs = 1'b1; tick(); a_rs = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (!a_busy) begin ok = 1'b1; break; end
      end
      total++;
      if (!ok) begin bad++; $display("FAIL rd1_timeout got busy=1 want 0"); end
      total++;
      if (a_rend !== 1'b1 || a_wend !== 1'b0 || a_irq !== 1'b1 || a_err !== 1'b0) begin
         bad++; $display("FAIL rd1_end got rend=%b wend=%b irq=%b err=%b want 1 0 1 0", a_rend, a_wend, a_irq, a_err);
      end
      total++;
      if (cmd_cnt != 1 || rc_q.size() != 0) begin
         bad++; $display("FAIL rd1_cmds got cmds=%0d left=%0d want 1 0", cmd_cnt, rc_q.size());
      end
      total++;
      if (rd_exp.size() != 6) begin bad++; $display("FAIL rd1_beats got %0d want 6", rd_exp.size()); end
      for (int i = 0; i < 6 && rd_exp.size() > 0; i++) begin
         logic [15:0] e = rd_exp.pop_front();
         total++;
         if (a_rvec[16*i +: 16] !== e) begin bad++; $display("FAIL rd1_word%0d got %h want %h", i, a_rvec[16*i +: 16], e); end
      end
      total++;
      if ((a_rvec >> 96) !== '0) begin bad++; $display("FAIL rd1_upper got nonzero want 0"); end
      tick();
      total++;
      if (a_rend !== 1'b0) begin bad++; $display("FAIL rd1_pulse got rend=%b want 0", a_rend); end
   endtask

   task automatic test_write_wait();
      bit ok = 1'b0;
      int nend = 0;
      sel = 1'b0; wait_mode = 1'b1;
      irq_clear = 1'b1; tick(); irq_clear = 1'b0;
      base = 32'h0; nelems = 30'd5;
      for (int k = 0; k < 10; k++) begin
         a_wvec[16*k +: 16] = 16'h5000 + 16'(k * 3);
         wr_q.push_back('{addr: (k < 8) ? 32'h0 : 32'h10, bc: (k < 8) ? 8 : 2, data: 16'h5000 + 16'(k * 3)});
      end
      a_ws = 1'b1; tick(); a_ws = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (a_wend) nend++;
         if (!a_busy) begin ok = 1'b1; break; end
      end
      tick();
      if (a_wend) nend++;
      wait_mode = 1'b0;
      total++;
      if (!ok) begin bad++; $display("FAIL wr_timeout got busy=1 want 0"); end
      total++;
      if (nend != 1 || a_rend !== 1'b0 || a_irq !== 1'b1 || a_err !== 1'b0) begin
         bad++; $display("FAIL wr_end got wend_pulses=%0d rend=%b irq=%b err=%b want 1 0 1 0", nend, a_rend, a_irq, a_err);
      end
      total++;
      if (wr_q.size() != 0) begin bad++; $display("FAIL wr_missing got left=%0d want 0", wr_q.size()); wr_q.delete(); end
   endtask

   task automatic test_pending_limit();
      bit ok = 1'b0;
      sel = 1'b1; hold = 1'b1; rd_exp.delete(); cmd_cnt = 0;
      base = 32'h400; nelems = 30'd16;
      for (int c = 0; c < 8; c++) rc_q.push_back('{addr: 32'h400 + 32'(8 * c), bc: 4});
      b_rs = 1'b1; tick(); b_rs = 1'b0;
      repeat (20) tick();
      total++;
      if (cmd_cnt != 2 || b_read !== 1'b0 || b_busy !== 1'b1) begin
         bad++; $display("FAIL pend_stall got cmds=%0d read=%b busy=%b want 2 0 1", cmd_cnt, b_read, b_busy);
      end
      hold = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (!b_busy) begin ok = 1'b1; break; end
      end
      total++;
      if (!ok) begin bad++; $display("FAIL pend_timeout got busy=1 want 0"); end
      total++;
      if (cmd_cnt != 8 || rc_q.size() != 0 || b_rend !== 1'b1 || b_irq !== 1'b1) begin
         bad++; $display("FAIL pend_done got cmds=%0d left=%0d rend=%b irq=%b want 8 0 1 1", cmd_cnt, rc_q.size(), b_rend, b_irq);
      end
      total++;
      if (rd_exp.size() != 32) begin bad++; $display("FAIL pend_beats got %0d want 32", rd_exp.size()); end
      for (int i = 0; i < 32 && rd_exp.size() > 0; i++) begin
         logic [15:0] e = rd_exp.pop_front();
         total++;
         if (b_rvec[16*i +: 16] !== e) begin bad++; $display("FAIL pend_word%0d got %h want %h", i, b_rvec[16*i +: 16], e); end
      end
      rc_q.delete(); sel = 1'b0;
   endtask

   task automatic test_errors();
      logic [31:0] bt[4] = '{32'h100, 32'h100, 32'h101, 32'h200};
      logic [29:0] nt[4] = '{30'd0, 30'd65, 30'd1, 30'd0};
      bit          wt[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      sel = 1'b0; bus_act = 0;
      for (int c = 0; c < 4; c++) begin
         irq_clear = 1'b1; tick(); irq_clear = 1'b0;
         base = bt[c]; nelems = nt[c];
         if (wt[c]) a_ws = 1'b1; else a_rs = 1'b1;
         tick();
         a_ws = 1'b0; a_rs = 1'b0;
         total++;
         if (a_busy !== 1'b1 || a_rend !== 1'b0 || a_wend !== 1'b0) begin
            bad++; $display("FAIL err%0d_done got busy=%b rend=%b wend=%b want 1 0 0", c, a_busy, a_rend, a_wend);
         end
         tick();
         total++;
         if (a_busy !== 1'b0 || a_rend !== !wt[c] || a_wend !== wt[c] || a_err !== 1'b1 || a_irq !== 1'b1) begin
            bad++; $display("FAIL err%0d_end got busy=%b rend=%b wend=%b err=%b irq=%b want 0 %b %b 1 1",
                            c, a_busy, a_rend, a_wend, a_err, a_irq, !wt[c], wt[c]);
         end
      end
      total++;
      if (bus_act != 0) begin bad++; $display("FAIL err_bus got active_cycles=%0d want 0", bus_act); end
      irq_clear = 1'b1; tick(); irq_clear = 1'b0;
      total++;
      if (a_irq !== 1'b0) begin bad++; $display("FAIL irq_clear got %b want 0", a_irq); end
   endtask

   task automatic test_priority_and_reset();
      bit ok = 1'b0;
      sel = 1'b0;
      base = 32'h20; nelems = 30'd2;
      for (int k = 0; k < 4; k++) begin
         a_wvec[16*k +: 16] = 16'h7700 + 16'(k);
         wr_q.push_back('{addr: 32'h20, bc: 4, data: 16'h7700 + 16'(k)});
      end
      irq_clear = 1'b1;
      a_rs = 1'b1; a_ws = 1'b1; tick(); a_rs = 1'b0; a_ws = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (!a_busy) begin ok = 1'b1; break; end
      end
      irq_clear = 1'b0;
      total++;
      if (!ok || a_wend !== 1'b1 || a_rend !== 1'b0 || a_err !== 1'b0) begin
         bad++; $display("FAIL prio got done=%b wend=%b rend=%b err=%b want 1 1 0 0", ok, a_wend, a_rend, a_err);
      end
      total++;
      if (a_irq !== 1'b1) begin bad++; $display("FAIL irq_set_wins got %b want 1", a_irq); end
      total++;
      if (wr_q.size() != 0) begin bad++; $display("FAIL prio_missing got left=%0d want 0", wr_q.size()); wr_q.delete(); end
      // long write, reset while bursting
      base = 32'h0; nelems = 30'd20;
      for (int k = 0; k < 40; k++) begin
         a_wvec[16*k +: 16] = 16'h3000 + 16'(k);
         wr_q.push_back('{addr: 32'((k / 8) * 16), bc: 8, data: 16'h3000 + 16'(k)});
      end
      a_ws = 1'b1; tick(); a_ws = 1'b0;
      tick(); tick();
      total++;
      if (a_write !== 1'b1 || a_busy !== 1'b1) begin bad++; $display("FAIL rst_midburst_pre got write=%b busy=%b want 1 1", a_write, a_busy); end
      reset = 1'b1; tick();
      total++;
      if ({a_read, a_write, a_addr, a_bc, a_wd, a_be, a_rend, a_wend, a_busy, a_err, a_irq} !== '0 || a_rvec !== '0) begin
         bad++; $display("FAIL rst_midburst got busy=%b write=%b addr=%h irq=%b want all 0", a_busy, a_write, a_addr, a_irq);
      end
      wr_q.delete();
      reset = 1'b0; bus_act = 0;
      repeat (6) tick();
      total++;
      if (bus_act != 0 || a_busy !== 1'b0) begin bad++; $display("FAIL rst_quiet got active=%0d busy=%b want 0 0", bus_act, a_busy); end
   endtask

   initial begin
      test_reset();
      test_read_burst();
      test_write_wait();
      test_pending_limit();
      test_errors();
      test_priority_and_reset();
      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
